// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP MAC back end: normalization bias, result
// classes in exception-priority order, and the LZA count width helper.
package fp_mac_pkg;

   // Unrounded sum MSB sits two places left of the product binary point.
   localparam int unsigned NormBias = 2;

   typedef enum logic [2:0] {
      CLS_NAN,
      CLS_INF,
      CLS_ZERO,
      CLS_OVF,
      CLS_UDF,
      CLS_NORM
   } exp_cls_e;

   function automatic int unsigned lzc_width(input int unsigned sig_w);
      return $clog2(3 * sig_w + 6);
   endfunction

endpackage

// File: rtl/exp_classify.sv
// Maps a final signed exponent plus special-case flags to the biased result
// exponent and per-result exception flags. Flush-to-zero, no denormals.
module exp_classify
   import fp_mac_pkg::*;
#(
   parameter int unsigned ex_width = 8
) (
   input  logic [ex_width+2:0] e_f_i,
   input  logic                nan_i,
   input  logic                inf_i,
   input  logic                zero_i,
   input  logic                prod_undf_i,
   output logic [ex_width-1:0] exp_o,
   output logic                ovf_o,
   output logic                udf_o,
   output logic                zero_o
);

   localparam int unsigned EW = ex_width + 3;
   localparam logic [EW-1:0] OvfLim = EW'((1 << ex_width) - 1);
   localparam logic [EW-1:0] One = EW'(1);

   logic     e_neg, e_nonpos, e_lt1, e_big;
   exp_cls_e cls;

   assign e_neg    = e_f_i[EW-1];
   assign e_nonpos = e_neg || (e_f_i == '0);
   assign e_lt1    = $signed(e_f_i) < $signed(One);
   assign e_big    = !e_neg && (e_f_i >= OvfLim);

   always_comb begin
      cls = CLS_NORM;
      if (nan_i)                               cls = CLS_NAN;
      else if (inf_i)                          cls = CLS_INF;
      else if (zero_i)                         cls = CLS_ZERO;
      else if (e_big)                          cls = CLS_OVF;
      else if (e_nonpos || (prod_undf_i && e_lt1)) cls = CLS_UDF;
   end

   always_comb begin
      exp_o  = '0;
      ovf_o  = 1'b0;
      udf_o  = 1'b0;
      zero_o = 1'b0;
      unique case (cls)
         CLS_NAN, CLS_INF: exp_o = '1;
         CLS_ZERO:         zero_o = 1'b1;
         CLS_OVF: begin
            exp_o = '1;
            ovf_o = 1'b1;
         end
         CLS_UDF:          udf_o = 1'b1;
         CLS_NORM:         exp_o = e_f_i[ex_width-1:0];
         default:          exp_o = '0;
      endcase
   end

endmodule

// File: rtl/exp_postnorm.sv
// Two-stage exponent post-normalization for the FP MAC: LZA adjust, rounding
// carry, classification, valid/ready handshake and sticky exception flags.
module exp_postnorm
   import fp_mac_pkg::*;
#(
   parameter int unsigned sig_width = 23,
   parameter int unsigned ex_width  = 8,
   parameter int unsigned lzc_w     = lzc_width(sig_width)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ex_width+1:0] max_exp,
   input  logic                prod_undf,
   input  logic [lzc_w-1:0]    lzc,
   input  logic                round_carry,
   input  logic                sum_zero,
   input  logic                in_inf,
   input  logic                in_nan,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ex_width-1:0] exp_out,
   output logic                ovf,
   output logic                udf,
   output logic                zero,
   input  logic                clr_flags,
   output logic                ovf_sticky,
   output logic                udf_sticky
);

   localparam int unsigned EW = ex_width + 3;

   logic                out_adv, accept, load;
   logic [EW-1:0]       e_n, e_f;
   logic [ex_width-1:0] c_exp;
   logic                c_ovf, c_udf, c_zero;

   logic                s1_valid_q, s1_valid_d;
   logic [EW-1:0]       s1_e_q, s1_e_d;
   logic                s1_rc_q, s1_rc_d, s1_zero_q, s1_zero_d;
   logic                s1_inf_q, s1_inf_d, s1_nan_q, s1_nan_d, s1_pu_q, s1_pu_d;

   logic                out_valid_q, out_valid_d;
   logic [ex_width-1:0] exp_q, exp_d;
   logic                ovf_q, ovf_d, udf_q, udf_d, zero_q, zero_d;
   logic                ovf_st_q, ovf_st_d, udf_st_q, udf_st_d;

   assign out_adv  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || out_adv;
   assign accept   = in_valid && in_ready;
   assign load     = out_adv && s1_valid_q;

   assign e_n = {max_exp[ex_width+1], max_exp} + EW'(NormBias)
              - {{(EW-lzc_w){1'b0}}, lzc};
   assign e_f = s1_e_q + {{(EW-1){1'b0}}, s1_rc_q};

   exp_classify #(
      .ex_width(ex_width)
   ) u_classify (
      .e_f_i      (e_f),
      .nan_i      (s1_nan_q),
      .inf_i      (s1_inf_q),
      .zero_i     (s1_zero_q),
      .prod_undf_i(s1_pu_q),
      .exp_o      (c_exp),
      .ovf_o      (c_ovf),
      .udf_o      (c_udf),
      .zero_o     (c_zero)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_e_d     = s1_e_q;
      s1_rc_d    = s1_rc_q;
      s1_zero_d  = s1_zero_q;
      s1_inf_d   = s1_inf_q;
      s1_nan_d   = s1_nan_q;
      s1_pu_d    = s1_pu_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_e_d     = e_n;
         s1_rc_d    = round_carry;
         s1_zero_d  = sum_zero;
         s1_inf_d   = in_inf;
         s1_nan_d   = in_nan;
         s1_pu_d    = prod_undf;
      end else if (out_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      out_valid_d = out_adv ? s1_valid_q : out_valid_q;
      exp_d       = load ? c_exp  : exp_q;
      ovf_d       = load ? c_ovf  : ovf_q;
      udf_d       = load ? c_udf  : udf_q;
      zero_d      = load ? c_zero : zero_q;
      // A newly loaded flag beats a simultaneous clear.
      ovf_st_d    = (load && c_ovf) || (ovf_st_q && !clr_flags);
      udf_st_d    = (load && c_udf) || (udf_st_q && !clr_flags);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_e_q      <= '0;
         s1_rc_q     <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_inf_q    <= 1'b0;
         s1_nan_q    <= 1'b0;
         s1_pu_q     <= 1'b0;
         out_valid_q <= 1'b0;
         exp_q       <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         zero_q      <= 1'b0;
         ovf_st_q    <= 1'b0;
         udf_st_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_e_q      <= s1_e_d;
         s1_rc_q     <= s1_rc_d;
         s1_zero_q   <= s1_zero_d;
         s1_inf_q    <= s1_inf_d;
         s1_nan_q    <= s1_nan_d;
         s1_pu_q     <= s1_pu_d;
         out_valid_q <= out_valid_d;
         exp_q       <= exp_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         zero_q      <= zero_d;
         ovf_st_q    <= ovf_st_d;
         udf_st_q    <= udf_st_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign exp_out    = exp_q;
   assign ovf        = ovf_q;
   assign udf        = udf_q;
   assign zero       = zero_q;
   assign ovf_sticky = ovf_st_q;
   assign udf_sticky = udf_st_q;

endmodule

// File: doc/exp_postnorm.md
Name: exp_postnorm

Overview:
- Back-end exponent stage of the FP MAC. Consumes the pre-normalization exponent produced by the front-end exponent logic, plus the LZA leading-zero count and the rounding carry-out from the significand datapath.
- Produces the final biased result exponent with overflow/underflow/special-case handling.
- 2-stage pipeline with valid/ready handshake, one result per cycle, plus sticky exception flags.

Parameters:
- sig_width, 23, significand fraction width (matches MAC datapath)
- ex_width, 8, exponent field width
- lzc_w, $clog2(3*sig_width+6), width of leading-zero count input

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  stage can accept input
- max_exp  in  ex_width+2  two's-complement pre-normalization exponent (front-end max_exp)
- prod_undf  in  1  product exponent underflow from front end
- lzc  in  lzc_w  leading-zero count of unnormalized sum, unsigned
- round_carry  in  1  significand overflow after rounding
- sum_zero  in  1  exact-zero sum
- in_inf  in  1  infinite operand result
- in_nan  in  1  NaN result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- exp_out  out  ex_width  final biased exponent
- ovf  out  1  overflow on this result
- udf  out  1  underflow (flush-to-zero) on this result
- zero  out  1  zero result
- clr_flags  in  1  clear sticky flags
- ovf_sticky  out  1  sticky overflow
- udf_sticky  out  1  sticky underflow

Behaviour:
- Reset (synchronous, rst=1 at clk edge): s1_valid=0, out_valid=0, exp_out=0, ovf=udf=zero=0, both sticky flags=0. Reset mid-stream discards all in-flight results; in_ready is 1 in the cycle after reset.
- Internal arithmetic is signed, ex_width+3 bits wide:
  - max_exp sign-extended; lzc zero-extended.
  - norm_bias=2 (sum MSB sits two positions left of the product binary point).
- Stage 1, registered on in_valid&&in_ready:
  - e_n = max_exp + norm_bias - lzc
  - latches round_carry, sum_zero, in_inf, in_nan, prod_undf.
- Stage 2, registered into output regs on s1 advance:
  - e_f = e_n + round_carry.
  - Classification priority: in_nan > in_inf > sum_zero > overflow > underflow > normal.
    - nan/inf: exp_out=all ones; ovf=udf=0; zero=0.
    - sum_zero: exp_out=0; zero=1; no flags.
    - overflow, e_f >= 2^ex_width-1: exp_out=all ones; ovf=1.
    - underflow, e_f <= 0, or prod_undf with e_f < 1: exp_out=0; udf=1 (flush-to-zero, no denormals).
    - normal: exp_out = e_f[ex_width-1:0].
- Handshake:
  - Output stage advances when !out_valid || out_ready.
  - in_ready = !s1_valid || output stage advancing.
  - Data is held stable while out_valid && !out_ready.
  - Latency: 2 cycles from accept to out_valid with no backpressure; throughput 1/cycle; no bubbles inserted, no drops, order preserved.
- Sticky flags:
  - Set when a result with ovf/udf is loaded into the output regs.
  - Cleared by clr_flags.
  - Simultaneous clr_flags and a new flagged result: set wins.

Decomposition:
- Shared fp_mac package holds: norm_bias, exception-priority enum (CLS_NAN, CLS_INF, CLS_ZERO, CLS_OVF, CLS_UDF, CLS_NORM), and the lzc_w function.
- One natural sub-module: exp_classify, purely combinational. It maps e_f plus special flags to exp_out/ovf/udf/zero and is reused by the FP adder back end.
- Pipeline registers and handshake stay in the top.

Test Plan:
- Normal result: max_exp=127, lzc=2, round_carry=0, out_ready=1 → out_valid 2 cycles later; exp_out=0x7F; all flags 0.
- Overflow boundary:
  - max_exp=251, lzc=0, rc=1 → exp_out=0xFE, ovf=0.
  - max_exp=252, lzc=0, rc=1 → exp_out=0xFF, ovf=1, ovf_sticky=1.
- Underflow: max_exp=3, lzc=10 → e_f=-5 → exp_out=0, udf=1, udf_sticky=1. Then clr_flags=1 in the same cycle as another underflow result loads → udf_sticky stays 1.
- Priority: in_nan=1, sum_zero=1, max_exp=300 (10-bit) → exp_out=0xFF, ovf=0, zero=0. Then sum_zero=1 alone → exp_out=0, zero=1.
- Backpressure: 4 back-to-back inputs (exp 10,20,30,40 with lzc=2) and out_ready=0 for 4 cycles → in_ready deasserts after 2 accepted. On release, outputs are 10,20,30,40 in order with no loss or duplication.
- Reset mid-stream: assert rst with both stages valid → next cycle out_valid=0, sticky flags=0, in_ready=1. Subsequent input completes normally in 2 cycles.
